// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and defaults for the FC weight scheduler and weight ROM
package fc_pkg;

    localparam int FC_DW       = 8;
    localparam int FC_ADDR_DW  = 5;
    localparam int FC_ROM_SIZE = 32;
    localparam int FC_LEN_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_STREAM    = 3'd3,
        ST_DRAIN     = 3'd4
    } state_t;

endpackage

// File: rtl/fc_weight_sched_if.sv
// rtl/fc_weight_sched_if.sv - weight stream interface to the FC MAC array
// master: drives w_data, w_valid, w_last; samples w_ready
// slave:  samples w_data, w_valid, w_last; drives w_ready
interface fc_weight_sched_if #(
    parameter int DW = 8
) ();
    logic [DW-1:0] w_data;
    logic          w_valid;
    logic          w_last;
    logic          w_ready;

    modport master (output w_data, output w_valid, output w_last, input w_ready);
    modport slave  (input w_data, input w_valid, input w_last, output w_ready);
endinterface

// File: rtl/fc_skid_buf.sv
// rtl/fc_skid_buf.sv - 2-entry {data, last} buffer absorbing ROM read latency
// Ports: clk, rst (sync, active-high); push/push_data/push_last write side;
//        pop read side; valid/head_data/head_last show the oldest entry; occ = entries held.
// Push and pop in the same cycle keep occupancy unchanged; caller never pushes when full.
module fc_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic          valid,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic [1:0]    occ
);
    logic [DW-1:0] data_q [2];
    logic          last_q [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            last_q[0] <= 1'b0;
            last_q[1] <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            cnt       <= 2'd0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign valid     = (cnt != 2'd0);
    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];
    assign occ       = cnt;
endmodule

// File: rtl/fc_weight_sched.sv
// rtl/fc_weight_sched.sv - FC weight ROM sequencer: init handshake, then weight runs over valid/ready
// Ports: clk, rst (sync, active-high); cfg_init/cfg_para ROM (re)initialise command;
//        start/start_addr/run_len run command; rom_* ROM control and read data;
//        w (weight stream master); busy, initialized, done, err status.
// Optional: FC_WSCHED_PERF_EN adds perf_stall, a saturating count of stalled-output cycles.
module fc_weight_sched
    import fc_pkg::*;
#(
    parameter int DW       = FC_DW,
    parameter int ADDR_DW  = FC_ADDR_DW,
    parameter int ROM_SIZE = FC_ROM_SIZE,
    parameter int LEN_W    = FC_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_init,
    input  logic [31:0]        cfg_para,
    input  logic               start,
    input  logic [ADDR_DW-1:0] start_addr,
    input  logic [LEN_W-1:0]   run_len,
    output logic               rom_init,
    output logic [31:0]        rom_para,
    output logic               rom_en,
    output logic [ADDR_DW-1:0] rom_addr,
    input  logic [DW-1:0]      rom_dout,
    input  logic               rom_init_ack,
    fc_weight_sched_if.master  w,
    output logic               busy,
    output logic               initialized,
    output logic               done,
`ifdef FC_WSCHED_PERF_EN
    output logic [31:0]        perf_stall,
`endif
    output logic               err
);
    state_t             state, state_n;
    logic               init_q;
    logic [31:0]        para_q;
    logic [ADDR_DW-1:0] addr_q;
    logic [LEN_W-1:0]   remaining_q;
    logic               inflight_q;
    logic               inflight_last_q;
    logic               done_zero_q;

    logic               accept;
    logic               issue;
    logic               pop;
    logic               final_issue;
    logic [2:0]         used;

    logic               buf_valid;
    logic [DW-1:0]      buf_data;
    logic               buf_last;
    logic [1:0]         buf_occ;

    fc_skid_buf #(.DW(DW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (rom_dout),
        .push_last (inflight_last_q),
        .pop       (pop),
        .valid     (buf_valid),
        .head_data (buf_data),
        .head_last (buf_last),
        .occ       (buf_occ)
    );

    assign pop  = buf_valid & w.w_ready;
    assign used = {1'b0, buf_occ} + {2'b00, inflight_q};
    // An entry popped this cycle frees its slot before the new read lands,
    // which is what lets a steady w_ready sustain one weight per cycle.
    assign issue       = (state == ST_STREAM) && (remaining_q != '0)
                         && (used < (3'd2 + {2'b00, pop}));
    assign final_issue = issue && (remaining_q == LEN_W'(1));

    always_comb begin
        state_n = state;
        err     = 1'b0;
        accept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_init) begin
                    state_n = ST_INIT;
                    err     = start;
                end else if (start) begin
                    if (!init_q) begin
                        err = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if (run_len != '0) state_n = ST_STREAM;
                    end
                end
            end
            ST_INIT: begin
                state_n = ST_INIT_WAIT;
                err     = start | cfg_init;
            end
            ST_INIT_WAIT: begin
                if (rom_init_ack) state_n = ST_IDLE;
                err = start | cfg_init;
            end
            ST_STREAM: begin
                if (final_issue) state_n = ST_DRAIN;
                err = start | cfg_init;
            end
            ST_DRAIN: begin
                if (pop && buf_last) state_n = ST_IDLE;
                err = start | cfg_init;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            init_q          <= 1'b0;
            para_q          <= '0;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_zero_q     <= 1'b0;
        end else begin
            state           <= state_n;
            inflight_q      <= issue;
            inflight_last_q <= final_issue;
            done_zero_q     <= accept && (run_len == '0);
            if (state == ST_IDLE && cfg_init) begin
                para_q <= cfg_para;
                init_q <= 1'b0;
            end
            if (state == ST_INIT_WAIT && rom_init_ack) begin
                init_q <= 1'b1;
            end
            if (accept) begin
                addr_q      <= start_addr;
                remaining_q <= run_len;
            end else if (issue) begin
                addr_q      <= (addr_q == ADDR_DW'(ROM_SIZE - 1)) ? '0 : addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

`ifdef FC_WSCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            perf_stall <= '0;
        end else if (buf_valid && !w.w_ready && perf_stall != '1) begin
            perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

    assign rom_init    = (state == ST_INIT);
    assign rom_para    = para_q;
    assign rom_en      = issue;
    assign rom_addr    = addr_q;
    assign busy        = (state != ST_IDLE);
    assign initialized = init_q;
    // The last-tagged entry can only reach the head after the final issue, i.e. in DRAIN.
    assign done        = done_zero_q | ((state == ST_DRAIN) && pop && buf_last);

    assign w.w_valid = buf_valid;
    assign w.w_data  = buf_data;
    assign w.w_last  = buf_last;
endmodule
